// File: rtl/types_pkg.sv
// Shared types for the instruction fetch path: the data bus type and the fetch FSM encoding.
package types_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef logic [DATA_W-1:0] DATA_BUS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state;

  // Fetch addresses are always word aligned; the low two bits of a target are dropped.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Single-outstanding-request instruction fetch unit with redirect handling.
// All outputs come straight from flops, so decode handshakes and redirects never reach an output combinationally.
module instr_fetch
  import types_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output DATA_BUS           instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target
);

  fetch_state        state;
  logic [ADDR_W-1:0] pc;
  // Set when the outstanding response belongs to a pre-redirect address.
  logic              drop;

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      pc_o        <= RESET_VECTOR;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (redirect) begin
        pc <= word_align(redirect_target);
      end

      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          if (imem_ready) begin
            state    <= WAIT;
            imem_req <= 1'b0;
            drop     <= redirect;
          end
        end

        WAIT: begin
          if (imem_rvalid) begin
            if (drop || redirect) begin
              state    <= FETCH;
              imem_req <= 1'b1;
              drop     <= 1'b0;
            end else begin
              instr       <= imem_rdata;
              pc_o        <= pc;
              pc          <= pc + 32'd4;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else if (redirect) begin
            drop <= 1'b1;
          end
        end

        HOLD: begin
          // A redirect alongside instr_ready still completes the handshake; both leave HOLD.
          if (redirect || instr_ready) begin
            state       <= FETCH;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          drop        <= 1'b0;
        end
      endcase
    end
  end

endmodule
